sd_async_fifo: RTL
==================

# sd_async_fifo

Parametrised dual-clock FIFO for the SD controller DMA data path. It is the successor to the fixed 32-bit TX/RX FIFOs. It adds Gray-coded pointer synchronisation between the write and read domains, configurable width and depth, and almost-full/almost-empty thresholds. It also reports a fill level in each clock domain and can optionally flag overflow/underflow. It sits between the Wishbone DMA master (write side) and the SD data serialiser (read side), or the reverse for the RX direction.

## Interface
- DATA_W, 32: data word width in bits.
- ADDR_W, 4: address width; depth is 2^ADDR_W words (minimum 2).
- AFULL_THR, 2^ADDR_W-2: `afull` is asserted when `wlevel` >= this value.
- AEMPTY_THR, 2: `aempty` is asserted when `rlevel` <= this value.
- SYNC_STAGES, 2: number of flip-flops in each pointer synchroniser (minimum 2).

- wclk  in  1  write-domain clock.
- rclk  in  1  read-domain clock.
- rst  in  1  reset, asynchronous, active-high. It resets both domains.
- Reset rst, asynchronous, active-high; clock wclk (write domain). The read domain runs on rclk.
- wr  in  1  write request.
- d  in  DATA_W  write data.
- full  out  1  FIFO full (wclk domain).
- afull  out  1  almost full (wclk domain).
- wlevel  out  ADDR_W+1  word count as seen from the write side.
- overflow  out  1  sticky flag: a write was attempted while full.
- rd  in  1  read request / pop.
- q  out  DATA_W  head-of-FIFO data (show-ahead).
- empty  out  1  FIFO empty (rclk domain).
- aempty  out  1  almost empty (rclk domain).
- rlevel  out  ADDR_W+1  word count as seen from the read side.
- underflow  out  1  sticky flag: a read was attempted while empty.

## Operation
- Pointers are ADDR_W+1 bits wide: a binary and a Gray copy in each domain. The RAM is indexed by the low ADDR_W bits of the binary pointer.
- Write accepted = `wr & ~full`. On acceptance, `d` is written to the RAM and the write pointer increments modulo 2^(ADDR_W+1).
- Read accepted = `rd & ~empty`. On acceptance, the read pointer increments.
- `q` = ram[rbin[ADDR_W-1:0]], combinational from the read pointer (first-word-fall-through). `q` is valid whenever `empty`=0 and is don't-care when `empty`=1.
- The write Gray pointer is synchronised into rclk through SYNC_STAGES flops. The read Gray pointer is synchronised into wclk the same way.
- `full` is registered. It is 1 when next wgray == synced rgray with its two MSBs inverted.
- `empty` is registered. It is 1 when next rgray == synced wgray.
- `wlevel` = wbin − gray2bin(synced rgray), computed in ADDR_W+1 bits. It is never an under-estimate of the words stored.
- `rlevel` = gray2bin(synced wgray) − rbin. It is never an over-estimate of the words available.
- `afull` and `aempty` are registered comparisons of next-state levels against the thresholds.
- Flags are pessimistic: a `full`/`empty` that has gone stale only delays traffic and never corrupts it.
- A rejected write (`wr` while `full`) or rejected read (`rd` while `empty`) leaves the pointers and RAM unchanged.
- Pointer wrap: the MSB toggles each time the pointer passes through 2^ADDR_W words. Full and empty stay distinct at every fill level from 0 to 2^ADDR_W.

## Timing
- Reset values: all pointers and synchronisers 0; `full`=0, `afull`=0, `wlevel`=0, `overflow`=0; `empty`=1, `aempty`=1, `rlevel`=0, `underflow`=0.
- RAM is not reset.
- Asserting `rst` mid-operation discards all contents immediately in both domains. Reset deassertion must be synchronised externally to each clock.
- Write-to-read latency: a word written on wclk edge N clears `empty` after at most SYNC_STAGES+1 rclk edges following edge N.
- Read-to-write latency: the read that frees a slot clears `full` after at most SYNC_STAGES+1 wclk edges.
- Same-domain flags update on the edge after the accepted access. A write that fills the last slot asserts `full` on that same edge.
- Write and read sides may operate on the same cycle in any clock ratio.

## Configuration
- `SD_FIFO_ERR_FLAGS_EN` defined: `overflow` and `underflow` logic is compiled in. `overflow` is set on `wr & full` (wclk domain) and `underflow` on `rd & empty` (rclk domain). Both are cleared only by `rst`.
- `SD_FIFO_ERR_FLAGS_EN` not defined: both outputs are tied to 0 and no flops are generated.

## Test plan
- Reset, then DATA_W=32, ADDR_W=4, same-frequency clocks: write 0x00..0x0F back-to-back. Required: `full`=1 after the 16th write; `wlevel`=16; a 17th write leaves data unchanged; `overflow`=1 if the macro is enabled.
- From full, read 16 words. Required: `q` sequence 0x00..0x0F; `empty`=1 after the last read; `rlevel`=0; a further `rd` sets `underflow`=1 (macro enabled) or leaves it 0 (macro disabled).
- wclk 100 MHz, rclk 33 MHz, random `wr`/`rd`, 10,000 words with pointers wrapping many times. Required: scoreboard match, no loss or duplication, `full` and `empty` never both 1.
- Single write into an empty FIFO. Required: `empty` falls within 3 rclk edges (SYNC_STAGES=2); `aempty` stays 1 until `rlevel` reaches 3.
- Fill to 14 words. Required: `afull` rises at `wlevel`=14 and falls when the synchronised level drops back to 13.
- Assert `rst` while holding 7 words. Required: all outputs return to their reset values asynchronously, and the next write/read pair returns the new word.

Source files
------------

// File: rtl/sd_async_fifo.sv
// rtl/sd_async_fifo.sv - dual-clock show-ahead FIFO with Gray-coded pointer synchronisation
//
// Purpose:
//   Carries DMA data words between the write clock domain (wclk) and the
//   read clock domain (rclk). The pointers are ADDR_W+1 bits wide, so full and
//   empty can be told apart at every fill level. Gray copies of the pointers
//   cross the clock domains through SYNC_STAGES-deep synchronisers.
//   Every flag is registered and pessimistic.
//
// Optional feature macro: SD_FIFO_ERR_FLAGS_EN
//   When it is defined, overflow and underflow are sticky flags that only rst
//   clears. When it is not defined, both outputs are tied to 0.
//
// Ports:
//   wclk      in   write-domain clock
//   rclk      in   read-domain clock
//   rst       in   asynchronous active-high reset, both domains
//   wr        in   write request (wclk)
//   d         in   write data [DATA_W]
//   full      out  FIFO full (wclk)
//   afull     out  almost full, wlevel >= AFULL_THR (wclk)
//   wlevel    out  word count seen from the write side [ADDR_W+1]
//   overflow  out  sticky: write attempted while full (wclk)
//   rd        in   read request / pop (rclk)
//   q         out  head-of-FIFO data, valid while empty=0 [DATA_W]
//   empty     out  FIFO empty (rclk)
//   aempty    out  almost empty, rlevel <= AEMPTY_THR (rclk)
//   rlevel    out  word count seen from the read side [ADDR_W+1]
//   underflow out  sticky: read attempted while empty (rclk)

module sd_async_fifo #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter int AFULL_THR   = (1 << ADDR_W) - 2,
    parameter int AEMPTY_THR  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              wclk,
    input  logic              rclk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] d,
    output logic              full,
    output logic              afull,
    output logic [ADDR_W:0]   wlevel,
    output logic              overflow,
    input  logic              rd,
    output logic [DATA_W-1:0] q,
    output logic              empty,
    output logic              aempty,
    output logic [ADDR_W:0]   rlevel,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [ADDR_W:0] AFULL_L  = (ADDR_W+1)'(AFULL_THR);
    localparam logic [ADDR_W:0] AEMPTY_L = (ADDR_W+1)'(AEMPTY_THR);
    // In Gray code, a pointer that is exactly one lap ahead differs from the
    // other pointer in its two most significant bits.
    localparam logic [ADDR_W:0] FULL_MASK = (ADDR_W+1)'(3 << (ADDR_W-1));

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Write domain
    // ------------------------------------------------------------------
    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] wgray;
    logic [ADDR_W:0] rgray;
    logic [ADDR_W:0] w_rsync [SYNC_STAGES];

    logic            w_acc;
    logic [ADDR_W:0] wbin_next;
    logic [ADDR_W:0] wgray_next;
    logic [ADDR_W:0] rgray_w;
    logic [ADDR_W:0] wlevel_next;

    assign w_acc       = wr & ~full;
    assign wbin_next   = wbin + {{ADDR_W{1'b0}}, w_acc};
    assign wgray_next  = bin2gray(wbin_next);
    assign rgray_w     = w_rsync[SYNC_STAGES-1];
    // The synchronised read pointer lags, so this count can only be too high.
    assign wlevel_next = wbin_next - gray2bin(rgray_w);

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                w_rsync[i] <= '0;
            end
        end else begin
            w_rsync[0] <= rgray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                w_rsync[i] <= w_rsync[i-1];
            end
        end
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            wbin   <= '0;
            wgray  <= '0;
            full   <= 1'b0;
            afull  <= 1'b0;
            wlevel <= '0;
        end else begin
            wbin   <= wbin_next;
            wgray  <= wgray_next;
            full   <= (wgray_next == (rgray_w ^ FULL_MASK));
            afull  <= (wlevel_next >= AFULL_L);
            wlevel <= wlevel_next;
        end
    end

    // The RAM is not reset. The write is gated by rst so that no word can be
    // written while the pointers are held at zero.
    always_ff @(posedge wclk) begin
        if (w_acc && !rst) begin
            mem[wbin[ADDR_W-1:0]] <= d;
        end
    end

    // ------------------------------------------------------------------
    // Read domain
    // ------------------------------------------------------------------
    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] r_wsync [SYNC_STAGES];

    logic            r_acc;
    logic [ADDR_W:0] rbin_next;
    logic [ADDR_W:0] rgray_next;
    logic [ADDR_W:0] wgray_r;
    logic [ADDR_W:0] rlevel_next;

    assign r_acc       = rd & ~empty;
    assign rbin_next   = rbin + {{ADDR_W{1'b0}}, r_acc};
    assign rgray_next  = bin2gray(rbin_next);
    assign wgray_r     = r_wsync[SYNC_STAGES-1];
    // The synchronised write pointer lags, so this count can only be too low.
    assign rlevel_next = gray2bin(wgray_r) - rbin_next;

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_wsync[i] <= '0;
            end
        end else begin
            r_wsync[0] <= wgray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_wsync[i] <= r_wsync[i-1];
            end
        end
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            rbin   <= '0;
            rgray  <= '0;
            empty  <= 1'b1;
            aempty <= 1'b1;
            rlevel <= '0;
        end else begin
            rbin   <= rbin_next;
            rgray  <= rgray_next;
            empty  <= (rgray_next == wgray_r);
            aempty <= (rlevel_next <= AEMPTY_L);
            rlevel <= rlevel_next;
        end
    end

    // Show-ahead: the head word is visible without a read strobe.
    assign q = mem[rbin[ADDR_W-1:0]];

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
`ifdef SD_FIFO_ERR_FLAGS_EN
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr && full) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (rd && empty) begin
            underflow <= 1'b1;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
